// File: rtl/nco_pkg.sv
// Shared definitions for the multi-channel NCO.
// Holds the waveform mode encodings, the default parameter values and the
// constant function that fills the quarter-wave sine ROM.
package nco_pkg;

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SAW    = 2'd3
    } nco_mode_e;

    localparam int DEF_PHASE_W = 32;
    localparam int DEF_ADDR_W  = 11;
    localparam int DEF_DATA_W  = 11;
    localparam int DEF_NUM_CH  = 2;

    localparam real NCO_PI = 3.14159265358979323846;

    // Quarter-wave magnitude at entry k, sampled at the bin centre (k+0.5)
    // so that mirrored quadrants reuse the table without a duplicated point.
    function automatic int nco_lut_entry(input int k, input int addr_w, input int data_w);
        real amp;
        real ang;
        amp = $itor((1 << (data_w - 1)) - 1);
        ang = 2.0 * NCO_PI * ($itor(k) + 0.5) / $itor(1 << addr_w);
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/sine_qlut.sv
// Quarter-wave sine ROM with a one-cycle registered read.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   ce         : read enable; mag holds its value when low
//   addr       : quarter-wave table index
//   mag        : registered magnitude, 0 .. 2^(DATA_W-1)-1
module sine_qlut
    import nco_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic [ADDR_W-3:0] addr,
    output logic [DATA_W-2:0] mag
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    logic [DATA_W-2:0] rom [DEPTH];
    logic [DATA_W-2:0] mag_q;
    logic [DATA_W-2:0] mag_d;

    // Table contents are elaboration-time constants.
    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam logic [DATA_W-2:0] ENTRY = (DATA_W - 1)'(nco_lut_entry(k, ADDR_W, DATA_W));
        assign rom[k] = ENTRY;
    end

    always_comb begin
        mag_d = mag_q;
        if (ce) begin
            mag_d = rom[addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mag_q <= '0;
        end else begin
            mag_q <= mag_d;
        end
    end

    assign mag = mag_q;

endmodule

// File: rtl/nco_multi.sv
// Multi-channel numerically controlled oscillator.
// Each channel has its own phase accumulator, frequency word, phase offset
// and waveform mode; all channels advance together on ce and produce one
// sample each through a 3-stage pipeline (phase reg, LUT read, fold/mux).
// Ports:
//   clk, reset            : clock and asynchronous active-high reset
//   ce                    : advance accumulators, launch one sample per channel
//   sync                  : zero all accumulators (wins over ce increment)
//   cfg_valid / cfg_ready : configuration handshake (ready=1 outside reset)
//   cfg_ch, cfg_fword, cfg_poff, cfg_mode : channel configuration write
//   cfg_err               : one-cycle pulse after a write to a missing channel
//   dout                  : channel i at [i*DATA_W +: DATA_W], offset binary
//   dout_valid            : dout carries new samples this cycle
module nco_multi
    import nco_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_CH  = DEF_NUM_CH,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce,
    input  logic                     sync,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [PHASE_W-1:0]       cfg_fword,
    input  logic [PHASE_W-1:0]       cfg_poff,
    input  logic [1:0]               cfg_mode,
    output logic                     cfg_err,
    output logic [NUM_CH*DATA_W-1:0] dout,
    output logic                     dout_valid
);

    localparam int LA_W  = ADDR_W - 2;
    localparam int TRI_W = DATA_W + 1;
    // Only the top phase bits are ever consumed downstream of the adder.
    localparam int S1_W  = (TRI_W > ADDR_W) ? TRI_W : ADDR_W;
    localparam logic [DATA_W-1:0] MID = DATA_W'(1) << (DATA_W - 1);

    logic [PHASE_W-1:0] acc_q   [NUM_CH], acc_d   [NUM_CH];
    logic [PHASE_W-1:0] fword_q [NUM_CH], fword_d [NUM_CH];
    logic [PHASE_W-1:0] poff_q  [NUM_CH], poff_d  [NUM_CH];
    nco_mode_e          mode_q  [NUM_CH], mode_d  [NUM_CH];

    logic [S1_W-1:0]    s1_phase_q [NUM_CH], s1_phase_d [NUM_CH];
    nco_mode_e          s1_mode_q  [NUM_CH], s1_mode_d  [NUM_CH];
    logic [TRI_W-1:0]   s2_top_q   [NUM_CH], s2_top_d   [NUM_CH];
    nco_mode_e          s2_mode_q  [NUM_CH], s2_mode_d  [NUM_CH];
    logic [DATA_W-1:0]  dout_q     [NUM_CH], dout_d     [NUM_CH];

    logic [LA_W-1:0]    lut_addr [NUM_CH];
    logic [DATA_W-2:0]  lut_mag  [NUM_CH];

    logic cfg_ready_q, cfg_err_q, cfg_err_d;
    logic s1_valid_q, s2_valid_q, dout_valid_q;
    logic cfg_accept, cfg_ch_ok;

    always_comb begin
        cfg_accept = cfg_valid && cfg_ready_q;
        cfg_ch_ok  = int'(cfg_ch) < NUM_CH;
        cfg_err_d  = cfg_accept && !cfg_ch_ok;

        for (int i = 0; i < NUM_CH; i++) begin
            fword_d[i] = fword_q[i];
            poff_d[i]  = poff_q[i];
            mode_d[i]  = mode_q[i];
            if (cfg_accept && cfg_ch_ok && (int'(cfg_ch) == i)) begin
                fword_d[i] = cfg_fword;
                poff_d[i]  = cfg_poff;
                mode_d[i]  = nco_mode_e'(cfg_mode);
            end

            // Accumulator keeps running across frequency changes; only sync zeroes it.
            acc_d[i] = acc_q[i];
            if (ce) begin
                acc_d[i] = acc_q[i] + fword_q[i];
            end
            if (sync) begin
                acc_d[i] = '0;
            end

            // S1 captures the pre-update phase and the mode in force at launch.
            s1_phase_d[i] = s1_phase_q[i];
            s1_mode_d[i]  = s1_mode_q[i];
            if (ce) begin
                s1_phase_d[i] = S1_W'((acc_q[i] + poff_q[i]) >> (PHASE_W - S1_W));
                s1_mode_d[i]  = mode_q[i];
            end

            // Odd quadrants run the table backwards.
            lut_addr[i] = s1_phase_q[i][S1_W-3 -: LA_W];
            if (s1_phase_q[i][S1_W-2]) begin
                lut_addr[i] = ~s1_phase_q[i][S1_W-3 -: LA_W];
            end

            s2_top_d[i]  = s2_top_q[i];
            s2_mode_d[i] = s2_mode_q[i];
            if (s1_valid_q) begin
                s2_top_d[i]  = s1_phase_q[i][S1_W-1 -: TRI_W];
                s2_mode_d[i] = s1_mode_q[i];
            end

            dout_d[i] = dout_q[i];
            if (s2_valid_q) begin
                case (s2_mode_q[i])
                    MODE_SINE:   dout_d[i] = s2_top_q[i][TRI_W-1] ? (MID - {1'b0, lut_mag[i]})
                                                                  : (MID + {1'b0, lut_mag[i]});
                    MODE_SQUARE: dout_d[i] = {DATA_W{~s2_top_q[i][TRI_W-1]}};
                    MODE_TRI:    dout_d[i] = s2_top_q[i][TRI_W-1] ? ~s2_top_q[i][DATA_W-1:0]
                                                                  :  s2_top_q[i][DATA_W-1:0];
                    MODE_SAW:    dout_d[i] = s2_top_q[i][TRI_W-1 -: DATA_W];
                    default:     dout_d[i] = dout_q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_ready_q  <= 1'b0;
            cfg_err_q    <= 1'b0;
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            dout_valid_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i]      <= '0;
                fword_q[i]    <= '0;
                poff_q[i]     <= '0;
                mode_q[i]     <= MODE_SINE;
                s1_phase_q[i] <= '0;
                s1_mode_q[i]  <= MODE_SINE;
                s2_top_q[i]   <= '0;
                s2_mode_q[i]  <= MODE_SINE;
                dout_q[i]     <= '0;
            end
        end else begin
            cfg_ready_q  <= 1'b1;
            cfg_err_q    <= cfg_err_d;
            s1_valid_q   <= ce;
            s2_valid_q   <= s1_valid_q;
            dout_valid_q <= s2_valid_q;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i]      <= acc_d[i];
                fword_q[i]    <= fword_d[i];
                poff_q[i]     <= poff_d[i];
                mode_q[i]     <= mode_d[i];
                s1_phase_q[i] <= s1_phase_d[i];
                s1_mode_q[i]  <= s1_mode_d[i];
                s2_top_q[i]   <= s2_top_d[i];
                s2_mode_q[i]  <= s2_mode_d[i];
                dout_q[i]     <= dout_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sine_qlut #(
            .ADDR_W(ADDR_W),
            .DATA_W(DATA_W)
        ) u_lut (
            .clk   (clk),
            .reset (reset),
            .ce    (s1_valid_q),
            .addr  (lut_addr[g]),
            .mag   (lut_mag[g])
        );
        assign dout[g*DATA_W +: DATA_W] = dout_q[g];
    end

    assign cfg_ready  = cfg_ready_q;
    assign cfg_err    = cfg_err_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_nco_multi.sv
// Scoreboard bench for nco_multi. Three channels are instantiated so that
// channel index 3 is representable on cfg_ch and is out of range.
module tb_nco_multi;

    localparam int NCH = 3;
    localparam int DW  = 11;

    logic            clk = 1'b0;
    logic            reset;
    logic            ce, sync, cfg_valid, cfg_ready, cfg_err, dout_valid;
    logic [1:0]      cfg_ch, cfg_mode;
    logic [31:0]     cfg_fword, cfg_poff;
    logic [NCH*DW-1:0] dout;

    nco_multi #(
        .PHASE_W(32), .ADDR_W(11), .DATA_W(DW), .NUM_CH(NCH)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .sync(sync),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_fword(cfg_fword), .cfg_poff(cfg_poff), .cfg_mode(cfg_mode),
        .cfg_err(cfg_err), .dout(dout), .dout_valid(dout_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                       n;
        logic [NCH-1:0][DW-1:0]   e;
    } exp_t;

    exp_t sb [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    logic [31:0] m_acc [NCH];
    logic [31:0] m_fw  [NCH];
    logic [31:0] m_po  [NCH];
    logic [1:0]  m_md  [NCH];
    int          ov    [NCH] = '{-1, -1, -1};
    int          smp = 0;
    int          first_ce_cyc = 0;
    bit          lat_pending = 1'b0;
    logic [NCH*DW-1:0] last_dout = '0;

    task automatic check(input string name, input int n, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s sample=%0d got=%0d want=%0d", name, n, act, exp);
        end
    endtask

    // Direct evaluation of the waveform formulas from the full phase.
    function automatic logic [DW-1:0] ref_sample(input logic [31:0] p, input logic [1:0] m);
        int idx;
        real s;
        real a;
        int mag;
        logic [11:0] t;
        case (m)
            2'd0: begin
                idx = int'(p[31:21]);
                s = $sin(2.0 * 3.14159265358979323846 * ($itor(idx) + 0.5) / 2048.0);
                a = (s < 0.0) ? -s : s;
                mag = $rtoi(1023.0 * a + 0.5);
                return (s >= 0.0) ? DW'(1024 + mag) : DW'(1024 - mag);
            end
            2'd1: return p[31] ? 11'd0 : 11'd2047;
            2'd2: begin
                t = p[31:20];
                return t[11] ? ~t[10:0] : t[10:0];
            end
            default: return p[31:21];
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_acc[i] = '0; m_fw[i] = '0; m_po[i] = '0; m_md[i] = 2'd0;
        end
    endtask

    // Drive one cycle of stimulus and advance the model in step with the DUT.
    task automatic cyc_drive(input bit c, input bit s, input bit v, input logic [1:0] ch,
                             input logic [31:0] fw, input logic [31:0] po, input logic [1:0] md);
        exp_t x;
        ce = c; sync = s; cfg_valid = v;
        cfg_ch = ch; cfg_fword = fw; cfg_poff = po; cfg_mode = md;
        if (c) begin
            x.n = smp;
            for (int i = 0; i < NCH; i++) begin
                x.e[i] = (ov[i] >= 0) ? DW'(ov[i]) : ref_sample(m_acc[i] + m_po[i], m_md[i]);
                ov[i] = -1;
            end
            sb.push_back(x);
            smp++;
            for (int i = 0; i < NCH; i++) m_acc[i] = m_acc[i] + m_fw[i];
        end
        if (s) begin
            for (int i = 0; i < NCH; i++) m_acc[i] = '0;
        end
        if (v && int'(ch) < NCH) begin
            m_fw[ch] = fw; m_po[ch] = po; m_md[ch] = md;
        end
        @(posedge clk);
        #1;
        ce = 1'b0; sync = 1'b0; cfg_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc_drive(0, 0, 0, 2'd0, 32'd0, 32'd0, 2'd0);
    endtask

    // Monitor: pop an expectation for every valid output, else check hold.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            last_dout <= '0;
        end else if (dout_valid) begin
            if (lat_pending) begin
                check("latency", 0, cyc - first_ce_cyc, 3);
                lat_pending = 1'b0;
            end
            if (sb.size() == 0) begin
                check("unexpected_valid", -1, 1, 0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                for (int c = 0; c < NCH; c++) begin
                    check($sformatf("ch%0d", c), x.n, dout[c*DW +: DW], x.e[c]);
                end
            end
            last_dout <= dout;
        end else begin
            check("hold", -1, dout, last_dout);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog sample=%0d got=timeout want=finish", smp);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        ce = 0; sync = 0; cfg_valid = 0; cfg_ch = 0; cfg_fword = 0; cfg_poff = 0; cfg_mode = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", 0, dout, 0);
        check("rst_dout_valid", 0, dout_valid, 0);
        check("rst_cfg_err", 0, cfg_err, 0);
        reset = 1'b0;
        check("ready_before_edge", 0, cfg_ready, 0);
        @(posedge clk);
        #1;
        check("ready_after_edge", 0, cfg_ready, 1);

        // Run A: sine and quadrature
        cyc_drive(0, 0, 1, 2'd0, 32'h0020_0000, 32'd0, 2'd0);
        cyc_drive(0, 0, 1, 2'd1, 32'h0020_0000, 32'h4000_0000, 2'd0);
        check("cfg_err_good", 0, cfg_err, 0);
        smp = 0;
        first_ce_cyc = cyc;
        lat_pending = 1'b1;
        for (int n = 0; n < 1600; n++) begin
            if (n == 0)    begin ov[0] = 1026; ov[1] = 2047; ov[2] = 1026; end
            if (n == 511)  ov[0] = 2047;
            if (n == 1024) ov[0] = 1022;
            if (n == 1535) ov[0] = 1;
            cyc_drive(1, 0, 0, 2'd0, 32'd0, 32'd0, 2'd0);
        end

        // Reset with samples still in the pipeline
        #2 reset = 1'b1;
        #1;
        check("midrst_dout", smp, dout, 0);
        check("midrst_valid", smp, dout_valid, 0);
        check("midrst_ready", smp, cfg_ready, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        check("midrst_ready_low", smp, cfg_ready, 0);
        @(posedge clk);
        #1;
        check("midrst_ready_high", smp, cfg_ready, 1);

        // Run B: phase continuity, bad write, sync
        cyc_drive(0, 0, 1, 2'd0, 32'h0020_0000, 32'd0, 2'd0);
        smp = 0;
        for (int n = 0; n < 800; n++) begin
            if (n == 701) begin ov[0] = 1026; ov[1] = 2047; end
            if (n == 100)
                cyc_drive(1, 0, 1, 2'd0, 32'h0040_0000, 32'd0, 2'd0);
            else if (n == 300)
                cyc_drive(1, 0, 1, 2'd3, 32'h1234_5678, 32'h8000_0000, 2'd3);
            else if (n == 700)
                cyc_drive(1, 1, 1, 2'd1, 32'h0080_0000, 32'h4000_0000, 2'd0);
            else
                cyc_drive(1, 0, 0, 2'd0, 32'd0, 32'd0, 2'd0);
            if (n == 300) check("bad_err_pulse", n, cfg_err, 1);
            if (n == 301) check("bad_err_clear", n, cfg_err, 0);
        end
        idle(6);

        // Modes at phase 0 and phase 2^31
        cyc_drive(0, 0, 1, 2'd0, 32'd0, 32'd0, 2'd1);
        cyc_drive(0, 0, 1, 2'd1, 32'd0, 32'd0, 2'd3);
        cyc_drive(0, 0, 1, 2'd2, 32'd0, 32'd0, 2'd2);
        cyc_drive(0, 1, 0, 2'd0, 32'd0, 32'd0, 2'd0);
        ov[0] = 2047; ov[1] = 0; ov[2] = 0;
        cyc_drive(1, 0, 0, 2'd0, 32'd0, 32'd0, 2'd0);
        cyc_drive(0, 0, 1, 2'd0, 32'd0, 32'h8000_0000, 2'd1);
        cyc_drive(0, 0, 1, 2'd1, 32'd0, 32'h8000_0000, 2'd3);
        cyc_drive(0, 0, 1, 2'd2, 32'd0, 32'h8000_0000, 2'd2);
        ov[0] = 0; ov[1] = 1024; ov[2] = 2047;
        cyc_drive(1, 0, 0, 2'd0, 32'd0, 32'd0, 2'd0);
        // Mode change in the launch cycle applies only to the next sample
        ov[0] = 0;
        cyc_drive(1, 0, 1, 2'd0, 32'd0, 32'h8000_0000, 2'd0);
        ov[0] = 1022;
        cyc_drive(1, 0, 0, 2'd0, 32'd0, 32'd0, 2'd0);
        idle(6);

        check("scoreboard_drained", smp, sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
